instr_encode: RTL and testbench

Packs an instruction-format code, register/function fields and a 32-bit immediate into a 32-bit RV32I instruction word. It is the inverse of the immediate-extraction path in decode. The code generator and self-test logic use it to build instruction words on chip before they are written to instruction memory. It is a 2-stage valid/ready pipeline with range checking and running counters.

---
 rtl/instr_encode.sv | 158 +++++++++++++++
 tb/tb_instr_encode.sv | 302 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/instr_encode.sv
// instr_encode: packs a format code, register/function fields and an immediate
// into a 32-bit RV32I instruction word. Two-stage valid/ready pipeline with
// immediate range checking and running handshake/error counters.
module instr_encode #(
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [2:0]       instr_format,
    input  logic [6:0]       opcode,
    input  logic [4:0]       rd,
    input  logic [4:0]       rs1,
    input  logic [4:0]       rs2,
    input  logic [2:0]       funct3,
    input  logic [6:0]       funct7,
    input  logic [31:0]      imm,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [31:0]      instr,
    output logic             err,
    output logic [CNT_W-1:0] enc_count,
    output logic [CNT_W-1:0] err_count
);

    // Format codes as defined by instr_type.hv; codes 6 and 7 are illegal.
    localparam logic [2:0] FMT_R = 3'd0;
    localparam logic [2:0] FMT_I = 3'd1;
    localparam logic [2:0] FMT_S = 3'd2;
    localparam logic [2:0] FMT_B = 3'd3;
    localparam logic [2:0] FMT_U = 3'd4;
    localparam logic [2:0] FMT_J = 3'd5;

    // Signed inclusive range check on the immediate.
    function automatic logic in_range(input logic signed [31:0] v,
                                      input logic signed [31:0] lo,
                                      input logic signed [31:0] hi);
        return (v >= lo) && (v <= hi);
    endfunction

    // Counter increment that sticks at all-ones.
    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
        return (&v) ? v : v + CNT_W'(1);
    endfunction

    logic               vld_p1;
    logic [2:0]         fmt_p1;
    logic [6:0]         opcode_p1;
    logic [4:0]         rd_p1;
    logic [4:0]         rs1_p1;
    logic [4:0]         rs2_p1;
    logic [2:0]         funct3_p1;
    logic [6:0]         funct7_p1;
    logic signed [31:0] imm_p1;

    logic [31:0]        instr_c;
    logic               err_c;
    logic               s1_adv;
    logic               s2_adv;

    // Stage advance: stage 2 drains on consume, stage 1 moves when stage 2 can take it.
    always_comb begin
        s2_adv   = !out_valid || out_ready;
        s1_adv   = !vld_p1 || s2_adv;
        in_ready = s1_adv;
    end

    // ---- stage 1: capture input fields on an input handshake ----
    // Stage-1 valid bit; data is captured alongside it without reset.
    always_ff @(posedge clk) begin
        if (reset) begin
            vld_p1 <= 1'b0;
        end else if (s1_adv) begin
            vld_p1 <= in_valid;
        end
    end

    // Stage-1 field registers, loaded only when an item is actually accepted.
    always_ff @(posedge clk) begin
        if (s1_adv && in_valid) begin
            fmt_p1    <= instr_format;
            opcode_p1 <= opcode;
            rd_p1     <= rd;
            rs1_p1    <= rs1;
            rs2_p1    <= rs2;
            funct3_p1 <= funct3;
            funct7_p1 <= funct7;
            imm_p1    <= imm;
        end
    end

    // Pack the word and evaluate the immediate checks from stage-1 fields.
    always_comb begin
        instr_c = '0;
        err_c   = 1'b0;
        case (fmt_p1)
            FMT_R: begin
                instr_c = {funct7_p1, rs2_p1, rs1_p1, funct3_p1, rd_p1, opcode_p1};
            end
            FMT_I: begin
                instr_c = {imm_p1[11:0], rs1_p1, funct3_p1, rd_p1, opcode_p1};
                err_c   = !in_range(imm_p1, -32'sd2048, 32'sd2047);
            end
            FMT_S: begin
                instr_c = {imm_p1[11:5], rs2_p1, rs1_p1, funct3_p1, imm_p1[4:0], opcode_p1};
                err_c   = !in_range(imm_p1, -32'sd2048, 32'sd2047);
            end
            FMT_B: begin
                instr_c = {imm_p1[12], imm_p1[10:5], rs2_p1, rs1_p1, funct3_p1,
                           imm_p1[4:1], imm_p1[11], opcode_p1};
                err_c   = !in_range(imm_p1, -32'sd4096, 32'sd4094) || imm_p1[0];
            end
            FMT_U: begin
                instr_c = {imm_p1[31:12], rd_p1, opcode_p1};
                err_c   = |imm_p1[11:0];
            end
            FMT_J: begin
                instr_c = {imm_p1[20], imm_p1[10:1], imm_p1[11], imm_p1[19:12], rd_p1, opcode_p1};
                err_c   = !in_range(imm_p1, -32'sd1048576, 32'sd1048574) || imm_p1[0];
            end
            default: begin
                instr_c = '0;
                err_c   = 1'b1;
            end
        endcase
    end

    // ---- stage 2: registered output word, error flag and valid ----
    // Output register; holds while the consumer stalls, clears valid when stage 1 is empty.
    always_ff @(posedge clk) begin
        if (reset) begin
            out_valid <= 1'b0;
            instr     <= '0;
            err       <= 1'b0;
        end else if (s2_adv) begin
            out_valid <= vld_p1;
            if (vld_p1) begin
                instr <= instr_c;
                err   <= err_c;
            end
        end
    end

    // Handshake counters: total wraps, error count saturates.
    always_ff @(posedge clk) begin
        if (reset) begin
            enc_count <= '0;
            err_count <= '0;
        end else if (out_valid && out_ready) begin
            enc_count <= enc_count + CNT_W'(1);
            if (err) begin
                err_count <= sat_inc(err_count);
            end
        end
    end

endmodule

// File: tb/tb_instr_encode.sv
// Directed testbench for instr_encode: per-feature tasks with hand-computed
// expected instruction words, error flags, counters and handshake timing.
module tb_instr_encode;

    localparam int CNT_W = 16;

    logic             clk;
    logic             reset;
    logic             in_valid;
    logic             in_ready;
    logic [2:0]       instr_format;
    logic [6:0]       opcode;
    logic [4:0]       rd;
    logic [4:0]       rs1;
    logic [4:0]       rs2;
    logic [2:0]       funct3;
    logic [6:0]       funct7;
    logic [31:0]      imm;
    logic             out_valid;
    logic             out_ready;
    logic [31:0]      instr;
    logic             err;
    logic [CNT_W-1:0] enc_count;
    logic [CNT_W-1:0] err_count;

    int tests;
    int fails;

    instr_encode #(.CNT_W(CNT_W)) dut (
        .clk          (clk),
        .reset        (reset),
        .in_valid     (in_valid),
        .in_ready     (in_ready),
        .instr_format (instr_format),
        .opcode       (opcode),
        .rd           (rd),
        .rs1          (rs1),
        .rs2          (rs2),
        .funct3       (funct3),
        .funct7       (funct7),
        .imm          (imm),
        .out_valid    (out_valid),
        .out_ready    (out_ready),
        .instr        (instr),
        .err          (err),
        .enc_count    (enc_count),
        .err_count    (err_count)
    );

    always #5 clk = ~clk;

    // Present a set of input fields (does not assert in_valid).
    task automatic drive(input logic [2:0] f, input logic [6:0] op, input logic [4:0] d,
                         input logic [4:0] a, input logic [4:0] b, input logic [2:0] f3,
                         input logic [6:0] f7, input logic [31:0] im);
        instr_format = f;
        opcode       = op;
        rd           = d;
        rs1          = a;
        rs2          = b;
        funct3       = f3;
        funct7       = f7;
        imm          = im;
    endtask

    // Hold in_valid until the item is accepted; returns 1 ns after the accepting edge.
    task automatic send();
        int n;
        n = 0;
        in_valid = 1'b1;
        while (!in_ready && n < 50) begin
            @(posedge clk); #1;
            n++;
        end
        if (!in_ready) begin
            tests++; fails++;
            $display("FAIL send_timeout: in_ready stayed 0 for %0d cycles", n);
        end
        @(posedge clk); #1;
        in_valid = 1'b0;
    endtask

    // Wait for out_valid, capture the output, and let it be consumed (out_ready=1).
    task automatic get_out(output logic [31:0] i, output logic e);
        int n;
        n = 0;
        while (!out_valid && n < 50) begin
            @(posedge clk); #1;
            n++;
        end
        if (!out_valid) begin
            tests++; fails++;
            $display("FAIL out_timeout: out_valid stayed 0 for %0d cycles", n);
        end
        i = instr;
        e = err;
        @(posedge clk); #1;
    endtask

    task automatic pulse_reset();
        reset = 1'b1;
        @(posedge clk); #1;
        reset = 1'b0;
    endtask

    task automatic test_reset();
        tests++;
        if (out_valid !== 1'b0) begin fails++; $display("FAIL reset_out_valid: got %b want 0", out_valid); end
        tests++;
        if (instr !== 32'h0) begin fails++; $display("FAIL reset_instr: got %h want 00000000", instr); end
        tests++;
        if (err !== 1'b0) begin fails++; $display("FAIL reset_err: got %b want 0", err); end
        tests++;
        if (enc_count !== '0 || err_count !== '0) begin
            fails++; $display("FAIL reset_counters: got enc=%0d err=%0d want 0 0", enc_count, err_count);
        end
        tests++;
        if (in_ready !== 1'b1) begin fails++; $display("FAIL reset_in_ready: got %b want 1", in_ready); end
    endtask

    task automatic test_i_format();
        out_ready = 1'b1;
        drive(3'd1, 7'h13, 5'd1, 5'd0, 5'd0, 3'd0, 7'd0, 32'hFFFF_FFFF);
        send();
        tests++;
        if (out_valid !== 1'b0) begin fails++; $display("FAIL i_latency_early: out_valid=%b want 0 one cycle after accept", out_valid); end
        @(posedge clk); #1;
        tests++;
        if (out_valid !== 1'b1) begin fails++; $display("FAIL i_latency: out_valid=%b want 1 two cycles after accept", out_valid); end
        tests++;
        if (instr !== 32'hFFF0_0093 || err !== 1'b0) begin
            fails++; $display("FAIL i_word: got %h err=%b want fff00093 err=0", instr, err);
        end
        @(posedge clk); #1;
        tests++;
        if (out_valid !== 1'b0) begin fails++; $display("FAIL i_drain: out_valid=%b want 0 after consume", out_valid); end
    endtask

    task automatic test_r_s_formats();
        logic [31:0] i;
        logic        e;
        out_ready = 1'b1;
        drive(3'd0, 7'h33, 5'd3, 5'd1, 5'd2, 3'd0, 7'h20, 32'h0000_0123);
        send(); get_out(i, e);
        tests++;
        if (i !== 32'h4020_81B3 || e !== 1'b0) begin fails++; $display("FAIL r_word: got %h err=%b want 402081b3 err=0", i, e); end
        drive(3'd2, 7'h23, 5'd0, 5'd1, 5'd2, 3'd2, 7'd0, 32'd8);
        send(); get_out(i, e);
        tests++;
        if (i !== 32'h0020_A423 || e !== 1'b0) begin fails++; $display("FAIL s_word: got %h err=%b want 0020a423 err=0", i, e); end
    endtask

    task automatic test_b_j_formats();
        logic [31:0] i;
        logic        e;
        out_ready = 1'b1;
        drive(3'd3, 7'h63, 5'd0, 5'd1, 5'd2, 3'd0, 7'd0, 32'hFFFF_FFFC);
        send(); get_out(i, e);
        tests++;
        if (i !== 32'hFE20_8EE3 || e !== 1'b0) begin fails++; $display("FAIL b_word: got %h err=%b want fe208ee3 err=0", i, e); end
        drive(3'd5, 7'h6F, 5'd1, 5'd0, 5'd0, 3'd0, 7'd0, 32'd8);
        send(); get_out(i, e);
        tests++;
        if (i !== 32'h0080_00EF || e !== 1'b0) begin fails++; $display("FAIL j_word: got %h err=%b want 008000ef err=0", i, e); end
    endtask

    task automatic test_u_format();
        logic [31:0] i;
        logic        e;
        out_ready = 1'b1;
        drive(3'd4, 7'h37, 5'd5, 5'd0, 5'd0, 3'd0, 7'd0, 32'h1234_5000);
        send(); get_out(i, e);
        tests++;
        if (i !== 32'h1234_52B7 || e !== 1'b0) begin fails++; $display("FAIL u_word: got %h err=%b want 123452b7 err=0", i, e); end
        drive(3'd4, 7'h37, 5'd5, 5'd0, 5'd0, 3'd0, 7'd0, 32'h1234_5001);
        send(); get_out(i, e);
        tests++;
        if (i !== 32'h1234_52B7 || e !== 1'b1) begin fails++; $display("FAIL u_low_bits: got %h err=%b want 123452b7 err=1", i, e); end
    endtask

    task automatic test_errors_counters();
        logic [31:0] i;
        logic        e;
        out_ready = 1'b1;
        pulse_reset();
        drive(3'd1, 7'h13, 5'd0, 5'd0, 5'd0, 3'd0, 7'd0, 32'd2048);
        send(); get_out(i, e);
        tests++;
        if (i !== 32'h8000_0013 || e !== 1'b1) begin fails++; $display("FAIL i_range_err: got %h err=%b want 80000013 err=1", i, e); end
        drive(3'd3, 7'h63, 5'd0, 5'd0, 5'd0, 3'd0, 7'd0, 32'd3);
        send(); get_out(i, e);
        tests++;
        if (i !== 32'h0000_0163 || e !== 1'b1) begin fails++; $display("FAIL b_odd_err: got %h err=%b want 00000163 err=1", i, e); end
        drive(3'd7, 7'h13, 5'd1, 5'd1, 5'd1, 3'd1, 7'd1, 32'd1);
        send(); get_out(i, e);
        tests++;
        if (i !== 32'h0 || e !== 1'b1) begin fails++; $display("FAIL illegal_fmt: got %h err=%b want 00000000 err=1", i, e); end
        tests++;
        if (enc_count !== 16'd3 || err_count !== 16'd3) begin
            fails++; $display("FAIL err_counters: got enc=%0d err=%0d want 3 3", enc_count, err_count);
        end
    endtask

    task automatic test_backpressure();
        out_ready = 1'b0;
        in_valid  = 1'b1;
        drive(3'd1, 7'h13, 5'd1, 5'd0, 5'd0, 3'd0, 7'd0, 32'd1);
        tests++;
        if (in_ready !== 1'b1) begin fails++; $display("FAIL bp_accept_a: in_ready=%b want 1", in_ready); end
        @(posedge clk); #1;
        drive(3'd1, 7'h13, 5'd2, 5'd0, 5'd0, 3'd0, 7'd0, 32'd2);
        tests++;
        if (in_ready !== 1'b1) begin fails++; $display("FAIL bp_accept_b: in_ready=%b want 1", in_ready); end
        @(posedge clk); #1;
        drive(3'd1, 7'h13, 5'd3, 5'd0, 5'd0, 3'd0, 7'd0, 32'd3);
        tests++;
        if (in_ready !== 1'b0) begin fails++; $display("FAIL bp_in_ready_drop: in_ready=%b want 0", in_ready); end
        tests++;
        if (out_valid !== 1'b1 || instr !== 32'h0010_0093) begin
            fails++; $display("FAIL bp_first_out: valid=%b instr=%h want 1 00100093", out_valid, instr);
        end
        repeat (2) begin @(posedge clk); #1; end
        tests++;
        if (out_valid !== 1'b1 || instr !== 32'h0010_0093 || err !== 1'b0 || in_ready !== 1'b0) begin
            fails++; $display("FAIL bp_hold: valid=%b instr=%h err=%b in_ready=%b want 1 00100093 0 0",
                              out_valid, instr, err, in_ready);
        end
        out_ready = 1'b1;
        #1;
        tests++;
        if (in_ready !== 1'b1) begin fails++; $display("FAIL bp_ready_comb: in_ready=%b want 1", in_ready); end
        @(posedge clk); #1;
        in_valid = 1'b0;
        tests++;
        if (out_valid !== 1'b1 || instr !== 32'h0020_0113) begin
            fails++; $display("FAIL bp_second_out: valid=%b instr=%h want 1 00200113", out_valid, instr);
        end
        @(posedge clk); #1;
        tests++;
        if (out_valid !== 1'b1 || instr !== 32'h0030_0193) begin
            fails++; $display("FAIL bp_third_out: valid=%b instr=%h want 1 00300193", out_valid, instr);
        end
        @(posedge clk); #1;
        tests++;
        if (out_valid !== 1'b0) begin fails++; $display("FAIL bp_drain: out_valid=%b want 0", out_valid); end
    endtask

    task automatic test_reset_midflight();
        int stale;
        out_ready = 1'b0;
        in_valid  = 1'b1;
        drive(3'd1, 7'h13, 5'd4, 5'd0, 5'd0, 3'd0, 7'd0, 32'd4);
        @(posedge clk); #1;
        drive(3'd1, 7'h13, 5'd5, 5'd0, 5'd0, 3'd0, 7'd0, 32'd5);
        @(posedge clk); #1;
        in_valid = 1'b0;
        tests++;
        if (out_valid !== 1'b1 || in_ready !== 1'b0) begin
            fails++; $display("FAIL mid_setup: out_valid=%b in_ready=%b want 1 0", out_valid, in_ready);
        end
        pulse_reset();
        tests++;
        if (out_valid !== 1'b0 || enc_count !== '0 || err_count !== '0 || instr !== 32'h0) begin
            fails++; $display("FAIL mid_reset: valid=%b enc=%0d err=%0d instr=%h want 0 0 0 00000000",
                              out_valid, enc_count, err_count, instr);
        end
        out_ready = 1'b1;
        stale = 0;
        repeat (4) begin
            @(posedge clk); #1;
            if (out_valid !== 1'b0) stale++;
        end
        tests++;
        if (stale != 0) begin fails++; $display("FAIL mid_stale: %0d cycles with out_valid after reset, want 0", stale); end
    endtask

    initial begin
        tests     = 0;
        fails     = 0;
        clk       = 1'b0;
        reset     = 1'b1;
        in_valid  = 1'b0;
        out_ready = 1'b1;
        drive(3'd0, 7'd0, 5'd0, 5'd0, 5'd0, 3'd0, 7'd0, 32'd0);
        repeat (2) @(posedge clk);
        #1;
        reset = 1'b0;

        test_reset();
        test_i_format();
        test_r_s_formats();
        test_b_j_formats();
        test_u_format();
        test_errors_counters();
        test_backpressure();
        test_reset_midflight();

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
